seq_alu: RTL and testbench

Multi-cycle, width-parametrised ALU for the RISCBlade datapath, superseding the single-cycle 16-bit add/subtract ALU. It accepts one operation per START and registers the result plus ZERO/NEG/OVF flags. Simple operations complete in one cycle. An optional iterative multiplier holds the block BUSY for WIDTH cycles. The block sits between the register-file read stage and writeback, and the control FSM stalls on BUSY.

---
 rtl/seq_alu_pkg.sv | 18 +
 rtl/seq_alu_mul.sv | 47 ++++
 rtl/seq_alu.sv | 139 +++++++++++++
 tb/tb_seq_alu.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcode and FSM state definitions for the multi-cycle seq_alu.
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per step, WIDTH steps.
module seq_alu_mul #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 load,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 step,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last
);

  localparam logic [SHAMT_W-1:0] LAST_CNT = SHAMT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [SHAMT_W-1:0] count_reg;

  // Accumulator value after the current step, so the final step's add is
  // visible in the same cycle the result is captured.
  assign product = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign last    = (count_reg == LAST_CNT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
    end else if (load) begin
      acc_reg    <= '0;
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      mplier_reg <= b;
      count_reg  <= '0;
    end else if (step) begin
      acc_reg    <= product;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with registered result and flags.
// Optional iterative multiplier enabled by defining SEQ_ALU_MUL_EN.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] SRCA,
  input  logic [WIDTH-1:0] SRCB,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] OUT,
  output logic             ZERO,
  output logic             NEG,
  output logic             OVF
);

  localparam int MSB = WIDTH - 1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             ovf_reg, ovf_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] sum, diff;

  assign sum  = SRCA + SRCB;
  assign diff = SRCA - SRCB;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (OP)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (SRCA[MSB] == SRCB[MSB]) && (sum[MSB] != SRCA[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (SRCA[MSB] != SRCB[MSB]) && (diff[MSB] != SRCA[MSB]);
      end
      OP_AND: alu_res = SRCA & SRCB;
      OP_OR:  alu_res = SRCA | SRCB;
      OP_XOR: alu_res = SRCA ^ SRCB;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(SRCA) < $signed(SRCB))};
      OP_SLL: alu_res = SRCA << SRCB[SHAMT_W-1:0];
      default: alu_res = '0;  // MUL without the multiplier yields zero
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  logic               mul_load, mul_step, mul_last;
  logic [2*WIDTH-1:0] mul_product;

  seq_alu_mul #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_mul (
    .CLK     (CLK),
    .RST     (RST),
    .load    (mul_load),
    .a       (SRCA),
    .b       (SRCB),
    .step    (mul_step),
    .product (mul_product),
    .last    (mul_last)
  );

  assign BUSY = (state_reg == S_MUL);
`else
  assign BUSY = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    ovf_next   = ovf_reg;
    done_next  = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    mul_load   = 1'b0;
    mul_step   = 1'b0;
`endif
    case (state_reg)
      S_IDLE: begin
        if (START) begin
`ifdef SEQ_ALU_MUL_EN
          if (OP == OP_MUL) begin
            mul_load   = 1'b1;
            state_next = S_MUL;
          end else
`endif
          begin
            out_next  = alu_res;
            ovf_next  = alu_ovf;
            done_next = 1'b1;
          end
        end
      end
      S_MUL: begin
`ifdef SEQ_ALU_MUL_EN
        mul_step = 1'b1;
        if (mul_last) begin
          out_next   = mul_product[WIDTH-1:0];
          ovf_next   = |mul_product[2*WIDTH-1:WIDTH];
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= S_IDLE;
      out_reg   <= '0;
      ovf_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      ovf_reg   <= ovf_next;
      done_reg  <= done_next;
    end
  end

  assign OUT  = out_reg;
  assign DONE = done_reg;
  assign OVF  = ovf_reg;
  assign ZERO = (out_reg == '0);
  assign NEG  = out_reg[MSB];

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=16 (MUL cases when SEQ_ALU_MUL_EN is defined).
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int WIDTH = 16;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             START = 1'b0;
  logic [2:0]       OP = 3'b000;
  logic [WIDTH-1:0] SRCA = '0;
  logic [WIDTH-1:0] SRCB = '0;
  logic             BUSY, DONE, ZERO, NEG, OVF;
  logic [WIDTH-1:0] OUT;

  int checks = 0;
  int failures = 0;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .SRCA(SRCA), .SRCB(SRCB),
    .BUSY(BUSY), .DONE(DONE), .OUT(OUT), .ZERO(ZERO), .NEG(NEG), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Presents one START for a cycle; returns at the sample after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge CLK);
    START = 1'b1; OP = op; SRCA = a; SRCB = b;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] res,
                          input logic z, input logic n, input logic v);
    issue(op, a, b);
    $display("txn %s op=%0d a=%h b=%h -> out=%h z=%b n=%b v=%b done=%b",
             tag, op, a, b, OUT, ZERO, NEG, OVF, DONE);
    check({tag, "_done"}, 32'(DONE), 32'(1'b1));
    check({tag, "_out"},  32'(OUT),  32'(res));
    check({tag, "_zero"}, 32'(ZERO), 32'(z));
    check({tag, "_neg"},  32'(NEG),  32'(n));
    check({tag, "_ovf"},  32'(OVF),  32'(v));
  endtask

`ifdef SEQ_ALU_MUL_EN
  // Waits for DONE after a MUL START, counting BUSY samples, DONE pulses and latency.
  task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit inject,
                         output int lat, output int busy_cnt, output int dones);
    issue(OP_MUL, a, b);
    lat = 0; busy_cnt = 0; dones = 0;
    while (DONE !== 1'b1 && lat < 40) begin
      if (BUSY === 1'b1) busy_cnt++;
      if (inject && lat == 3) begin
        START = 1'b1; OP = OP_ADD; SRCA = 16'h0001; SRCB = 16'h0001;
      end else if (inject && lat == 4) begin
        START = 1'b0; SRCA = 16'h1234; SRCB = 16'h5678;
      end
      @(negedge CLK);
      lat++;
    end
    if (DONE === 1'b1) dones++;
    $display("txn MUL a=%h b=%h -> out=%h z=%b v=%b lat=%0d busy=%0d", a, b, OUT, ZERO, OVF, lat, busy_cnt);
  endtask
`endif

  initial begin
    int lat, busy_cnt, dones, extra;

    repeat (2) @(negedge CLK);
    check("rst_out",  32'(OUT),  32'h0);
    check("rst_zero", 32'(ZERO), 32'h1);
    check("rst_neg",  32'(NEG),  32'h0);
    check("rst_ovf",  32'(OVF),  32'h0);
    check("rst_busy", 32'(BUSY), 32'h0);
    check("rst_done", 32'(DONE), 32'h0);
    RST = 1'b0;

    op_check("add_5_5",   OP_ADD, 16'h0005, 16'h0005, 16'h000A, 0, 0, 0);
    @(negedge CLK);
    check("done_single_pulse", 32'(DONE), 32'h0);
    check("out_holds",         32'(OUT),  32'h000A);
    op_check("add_5_m3",  OP_ADD, 16'h0005, 16'hFFFD, 16'h0002, 0, 0, 0);
    op_check("add_m5_m3", OP_ADD, 16'hFFFB, 16'hFFFD, 16'hFFF8, 0, 1, 0);
    op_check("sub_5_5",   OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1, 0, 0);
    op_check("add_ovf",   OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 1);
    op_check("sub_ovf",   OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 1);
    op_check("slt_m3_2",  OP_SLT, 16'hFFFD, 16'h0002, 16'h0001, 0, 0, 0);
    op_check("slt_2_m3",  OP_SLT, 16'h0002, 16'hFFFD, 16'h0000, 1, 0, 0);
    op_check("sll_1_15",  OP_SLL, 16'h0001, 16'h000F, 16'h8000, 0, 1, 0);
    op_check("sll_hi_bits_ignored", OP_SLL, 16'h0003, 16'hFFF1, 16'h0006, 0, 0, 0);
    op_check("xor_ffff",  OP_XOR, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 0, 0);
    op_check("and",       OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 0, 1, 0);
    op_check("or",        OP_OR,  16'h00F0, 16'h0F00, 16'h0FF0, 0, 0, 0);

`ifdef SEQ_ALU_MUL_EN
    run_mul(16'd300, 16'd7, 1'b0, lat, busy_cnt, dones);
    check("mul1_latency", 32'(lat),      32'd16);
    check("mul1_busy",    32'(busy_cnt), 32'd16);
    check("mul1_done",    32'(dones),    32'd1);
    check("mul1_busy_at_done", 32'(BUSY), 32'h0);
    check("mul1_out",     32'(OUT),      32'h0834);
    check("mul1_ovf",     32'(OVF),      32'h0);

    run_mul(16'h0100, 16'h0100, 1'b1, lat, busy_cnt, dones);
    check("mul2_latency", 32'(lat),  32'd16);
    check("mul2_done",    32'(dones), 32'd1);
    check("mul2_out",     32'(OUT),  32'h0000);
    check("mul2_zero",    32'(ZERO), 32'h1);
    check("mul2_ovf",     32'(OVF),  32'h1);
    // ADD presented in the DONE cycle must be accepted immediately.
    START = 1'b1; OP = OP_ADD; SRCA = 16'h0002; SRCB = 16'h0003;
    @(negedge CLK);
    START = 1'b0;
    $display("txn b2b_add -> out=%h done=%b", OUT, DONE);
    check("b2b_done", 32'(DONE), 32'h1);
    check("b2b_out",  32'(OUT),  32'h0005);
    @(negedge CLK);
    check("after_mul_no_extra_done", 32'(DONE), 32'h0);

    issue(OP_MUL, 16'd300, 16'd7);
    repeat (4) @(negedge CLK);
    check("midmul_busy", 32'(BUSY), 32'h1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
`else
    op_check("mul_disabled", OP_MUL, 16'd300, 16'd7, 16'h0000, 1, 0, 0);
    check("mul_disabled_busy", 32'(BUSY), 32'h0);
    op_check("pre_rst_add", OP_ADD, 16'h0004, 16'h0004, 16'h0008, 0, 0, 0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
`endif
    $display("txn reset -> out=%h z=%b busy=%b done=%b", OUT, ZERO, BUSY, DONE);
    check("rst2_out",  32'(OUT),  32'h0);
    check("rst2_zero", 32'(ZERO), 32'h1);
    check("rst2_busy", 32'(BUSY), 32'h0);
    check("rst2_done", 32'(DONE), 32'h0);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) extra++;
    end
    check("rst2_no_done", 32'(extra), 32'h0);
    op_check("add_2_3", OP_ADD, 16'h0002, 16'h0003, 16'h0005, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
